alu_result_queue: RTL and testbench

//  Downstream stage of the ALU. Captures each ALU result with its opcode tag and

---
 rtl/alu_result_queue_if.sv | 34 +++
 rtl/alu_result_queue.sv | 77 +++++++
 tb/tb_alu_result_queue.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_result_queue_if.sv
// Handshake/bus bundle for alu_result_queue: producer-side push channel,
// consumer-side head channel and occupancy/debug status.
interface alu_result_queue_if #(
    parameter int unsigned DW  = 32,
    parameter int unsigned OPW = 3,
    parameter int unsigned AW  = 2
);
    logic           in_valid;
    logic           in_ready;
    logic [DW-1:0]  in_result;
    logic [OPW-1:0] in_op;
    logic           out_valid;
    logic           out_ready;
    logic [DW-1:0]  out_result;
    logic [OPW-1:0] out_op;
    logic           out_zero;
    logic           out_neg;
    logic [AW:0]    count;
    logic           full;
    logic           empty;
    logic [15:0]    pop_cnt;

    modport slave (
        input  in_valid, in_result, in_op, out_ready,
        output in_ready, out_valid, out_result, out_op, out_zero, out_neg,
               count, full, empty, pop_cnt
    );

    modport master (
        output in_valid, in_result, in_op, out_ready,
        input  in_ready, out_valid, out_result, out_op, out_zero, out_neg,
               count, full, empty, pop_cnt
    );
endinterface

// File: rtl/alu_result_queue.sv
// ALU result FIFO: tags each result with its opcode and zero/negative flags at
// capture, buffers DEPTH entries with valid/ready on both sides.
module alu_result_queue #(
    parameter int unsigned DW    = 32,
    parameter int unsigned OPW   = 3,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_result_queue_if.slave q
);
    localparam int unsigned EW = DW + OPW + 2;

    logic [EW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [15:0]   pop_cnt_q, pop_cnt_d;
    logic          full, empty, push, pop;
    logic [EW-1:0] wr_entry, head;

    always_comb begin
        full     = (count_q == (AW+1)'(DEPTH));
        empty    = (count_q == '0);
        push     = q.in_valid && !full;
        pop      = q.out_ready && !empty;
        wr_entry = {q.in_result, q.in_op, (q.in_result == '0), q.in_result[DW-1]};

        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        pop_cnt_d = pop_cnt_q;
        count_d   = count_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop) begin
            rd_ptr_d  = rd_ptr_q + AW'(1);
            pop_cnt_d = pop_cnt_q + 16'd1;
        end
        // Simultaneous push and pop leaves occupancy unchanged.
        unique case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            pop_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            pop_cnt_q <= pop_cnt_d;
        end
    end

    // Storage is deliberately left uncleared by reset.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_entry;
    end

    assign head         = mem_q[rd_ptr_q];
    assign q.out_result = head[EW-1 -: DW];
    assign q.out_op     = head[OPW+1:2];
    assign q.out_zero   = head[1];
    assign q.out_neg    = head[0];
    assign q.out_valid  = !empty;
    assign q.in_ready   = !full;
    assign q.count      = count_q;
    assign q.full       = full;
    assign q.empty      = empty;
    assign q.pop_cnt    = pop_cnt_q;
endmodule

// File: tb/tb_alu_result_queue.sv
// Self-checking bench for alu_result_queue: scoreboard on every pop plus
// directed sequences for ordering, flags, full/stall, wrap and async reset.
module tb_alu_result_queue;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [37:0] sb[$];

    always #5 clk = ~clk;

    alu_result_queue_if #(.DW(32), .OPW(3), .AW(2)) q ();

    alu_result_queue #(.DW(32), .OPW(3), .DEPTH(4), .AW(2)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .q    (q)
    );

    typedef struct {
        logic [31:0] result;
        logic [2:0]  op;
        logic        zero;
        logic        neg;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [31:0] r, input logic [2:0] op);
        q.in_valid  = 1'b1;
        q.in_result = r;
        q.in_op     = op;
        step();
        q.in_valid  = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n       = 1'b0;
        q.in_valid  = 1'b0;
        q.out_ready = 1'b0;
        sb.delete();
        #2;
        rst_n = 1'b1;
        step();
    endtask

    // Scoreboard: status vs model occupancy every cycle, head vs oldest push on every pop.
    always @(negedge clk) begin
        if (rst_n) begin
            automatic int n = sb.size();
            automatic logic [6:0] st_exp = {3'(n), n == 4, n == 0, n != 4, n != 0};
            chk("status", {q.count, q.full, q.empty, q.in_ready, q.out_valid}, st_exp);
            if (q.out_valid && q.out_ready) begin
                if (n == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow actual=pop required=no_pop");
                end else begin
                    chk("head", {q.out_result, q.out_op, q.out_zero, q.out_neg}, sb.pop_front());
                end
            end
            if (q.in_valid && q.in_ready)
                sb.push_back({q.in_result, q.in_op, q.in_result == 32'd0, q.in_result[31]});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[4];
        int   acc;
        logic [31:0] v;
        tbl[0] = '{32'd30,         3'b000, 1'b0, 1'b0};
        tbl[1] = '{32'd20,         3'b001, 1'b0, 1'b0};
        tbl[2] = '{32'd0,          3'b010, 1'b1, 1'b0};
        tbl[3] = '{32'hFFFF_FFF6,  3'b001, 1'b0, 1'b1};

        // 1: reset with a push pending, then out_ready on an empty queue
        q.in_valid  = 1'b1;
        q.in_result = 32'd55;
        q.in_op     = 3'd1;
        q.out_ready = 1'b0;
        #3;
        chk("rst_count", q.count, 0);
        chk("rst_flags", {q.empty, q.full, q.in_ready, q.out_valid}, 4'b1010);
        chk("rst_popcnt", q.pop_cnt, 0);
        repeat (2) @(negedge clk);
        chk("rst_hold_count", q.count, 0);
        q.in_valid = 1'b0;
        #2;
        rst_n = 1'b1;
        step();
        q.out_ready = 1'b1;
        repeat (2) step();
        q.out_ready = 1'b0;
        @(negedge clk);
        chk("empty_pop_ignored", q.pop_cnt, 0);

        // 2: ordering and flags
        do_reset();
        for (int i = 0; i < 4; i++) push_one(tbl[i].result, tbl[i].op);
        @(negedge clk);
        chk("t2_count", q.count, 4);
        @(posedge clk);
        #1;
        q.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t2_result", q.out_result, tbl[i].result);
            chk("t2_op", q.out_op, tbl[i].op);
            chk("t2_zero", q.out_zero, tbl[i].zero);
            chk("t2_neg", q.out_neg, tbl[i].neg);
            step();
        end
        q.out_ready = 1'b0;
        @(negedge clk);
        chk("t2_popcnt", q.pop_cnt, 4);
        chk("t2_empty", q.empty, 1);

        // 3: full and stall
        do_reset();
        v   = 32'd100;
        acc = 0;
        q.in_valid = 1'b1;
        q.in_op    = 3'd5;
        for (int c = 0; c < 6; c++) begin
            q.in_result = v;
            @(negedge clk);
            if (q.in_ready) begin
                acc++;
                v = v + 32'd1;
            end
            step();
        end
        @(negedge clk);
        chk("t3_accepted", acc, 4);
        chk("t3_full", {q.full, q.in_ready, q.count}, {1'b1, 1'b0, 3'd4});
        step();
        q.out_ready = 1'b1;
        step();
        q.out_ready = 1'b0;
        @(negedge clk);
        chk("t3_after_pop", q.count, 3);
        step();
        q.in_valid = 1'b0;
        @(negedge clk);
        chk("t3_refill", q.count, 4);
        step();
        @(negedge clk);
        chk("t3_stays_full", q.count, 4);
        step();
        q.out_ready = 1'b1;
        repeat (3) step();
        @(negedge clk);
        chk("t3_fifth_popped", q.out_result, 32'd104);
        step();
        q.out_ready = 1'b0;
        @(negedge clk);
        chk("t3_popcnt", q.pop_cnt, 5);

        // 4: simultaneous push/pop at count=2
        do_reset();
        push_one(32'h11, 3'd1);
        push_one(32'h22, 3'd2);
        q.in_valid  = 1'b1;
        q.in_result = 32'h33;
        q.in_op     = 3'd3;
        q.out_ready = 1'b1;
        step();
        q.in_valid  = 1'b0;
        q.out_ready = 1'b0;
        @(negedge clk);
        chk("t4_count", q.count, 2);
        chk("t4_head", q.out_result, 32'h22);
        step();
        q.out_ready = 1'b1;
        step();
        @(negedge clk);
        chk("t4_last", q.out_result, 32'h33);
        step();
        q.out_ready = 1'b0;

        // 5: wrap-around at steady state
        do_reset();
        push_one(32'd1000, 3'd0);
        q.in_valid  = 1'b1;
        q.out_ready = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            q.in_result = 32'd1000 + 32'(k);
            q.in_op     = 3'(k);
            step();
        end
        q.in_valid  = 1'b0;
        q.out_ready = 1'b0;
        @(negedge clk);
        chk("t5_popcnt", q.pop_cnt, 10);
        chk("t5_count", q.count, 1);
        chk("t5_head", q.out_result, 32'd1010);
        step();
        q.out_ready = 1'b1;
        step();
        q.out_ready = 1'b0;

        // 6: asynchronous reset mid-operation
        do_reset();
        push_one(32'd7, 3'd1);
        push_one(32'd8, 3'd2);
        push_one(32'd9, 3'd3);
        @(negedge clk);
        chk("t6_pre", {q.count, q.out_valid}, {3'd3, 1'b1});
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("t6_async", {q.count, q.out_valid}, {3'd0, 1'b0});
        #1;
        rst_n = 1'b1;
        step();
        push_one(32'd5, 3'd6);
        @(negedge clk);
        chk("t6_head", {q.out_valid, q.out_result}, {1'b1, 32'd5});
        step();
        q.out_ready = 1'b1;
        step();
        q.out_ready = 1'b0;
        @(negedge clk);
        chk("t6_done", {q.empty, q.pop_cnt}, {1'b1, 16'd1});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
